// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// alu_muldiv_seq : 16-bit unsigned multiply/divide sequencer on a shared ALU
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result_lo,
  output logic [15:0] result_hi,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  input  logic [15:0] alu_result
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DCMP = 3'd2,
    S_DSUB = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] acc;
  logic [15:0] rem;
  logic [15:0] rem_s_q;
  logic [15:0] q;
  logic [3:0]  cnt;
  logic        top;
  logic        lt;

  logic [15:0] rem_s;
  logic [15:0] rem_new;
  logic [15:0] q_new;
  logic [15:0] a_shift;
  logic        take;

  // Restoring-division step values; top covers the 17th bit lost by the shift.
  always_comb begin
    rem_s   = {rem[14:0], a_q[cnt]};
    take    = top | ~lt;
    rem_new = take ? alu_result : rem_s_q;
    q_new   = q | (16'(take) << cnt);
    a_shift = a_q << cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_ctrl  = ALU_ADD;
    alu_src1  = 16'h0000;
    alu_src2  = 16'h0000;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!op)                    state_nxt = S_MUL;
          else if (operand_b == 16'h0) state_nxt = S_DONE;
          else                        state_nxt = S_DCMP;
        end
      end
      S_MUL: begin
        busy     = 1'b1;
        alu_ctrl = ALU_ADD;
        alu_src1 = acc;
        alu_src2 = b_q[cnt] ? a_shift : 16'h0000;
        if (cnt == 4'd15) state_nxt = S_DONE;
      end
      S_DCMP: begin
        busy      = 1'b1;
        alu_ctrl  = ALU_SLT;
        alu_src1  = rem_s;
        alu_src2  = b_q;
        state_nxt = S_DSUB;
      end
      S_DSUB: begin
        busy      = 1'b1;
        alu_ctrl  = ALU_SUB;
        alu_src1  = rem_s_q;
        alu_src2  = b_q;
        state_nxt = (cnt == 4'd0) ? S_DONE : S_DCMP;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Results are captured on entry to DONE so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      acc       <= 16'h0000;
      rem       <= 16'h0000;
      rem_s_q   <= 16'h0000;
      q         <= 16'h0000;
      cnt       <= 4'd0;
      top       <= 1'b0;
      lt        <= 1'b0;
      result_lo <= 16'h0000;
      result_hi <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q <= operand_a;
            b_q <= operand_b;
            acc <= 16'h0000;
            rem <= 16'h0000;
            q   <= 16'h0000;
            cnt <= op ? 4'd15 : 4'd0;
            if (op && (operand_b == 16'h0)) begin
              result_lo <= 16'hFFFF;
              result_hi <= operand_a;
            end
          end
        end
        S_MUL: begin
          acc <= alu_result;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            result_lo <= alu_result;
            result_hi <= 16'h0000;
          end
        end
        S_DCMP: begin
          rem_s_q <= rem_s;
          top     <= rem[15];
          lt      <= alu_result[0];
        end
        S_DSUB: begin
          rem <= rem_new;
          q   <= q_new;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            result_lo <= q_new;
            result_hi <= rem_new;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that performs unsigned 16-bit multiply (low half) and unsigned 16-bit divide by driving the CPU's shared 16-bit ALU one operation per cycle. It uses only the ALU's add (4'b0010), subtract (4'b0110) and set-less-than (4'b0111) codes. It sits beside the ALU in the datapath. While the controller is busy, it owns the ALU operand and control inputs, and the CPU stalls on `busy`.

## Interface
- No parameters. Width is fixed at 16 to match the ALU.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide. Sampled with start.
- operand_a  in  16  multiplicand or dividend. Sampled with start.
- operand_b  in  16  multiplier or divisor. Sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results are valid in that cycle.
- result_lo  out  16  product[15:0] or quotient.
- result_hi  out  16  remainder for divide; 0 for multiply.
- alu_src1  out  16  drives ALU source1.
- alu_src2  out  16  drives ALU source2.
- alu_ctrl  out  4  drives ALU_CTRL.
- alu_result  in  16  ALU result; combinational from alu_src1/alu_src2/alu_ctrl.

## Operation
- States: IDLE, MUL, DCMP, DSUB, DONE. Bit counter i is 4 bits.
- Reset values: state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, alu_src1=0, alu_src2=0, alu_ctrl=4'b0010.
- **IDLE**
  - Drives the ALU with add 0+0.
  - start=1 latches op, operand_a and operand_b.
  - Multiply: i=0, acc=0, next state MUL.
  - Divide with operand_b≠0: i=15, rem=0, q=0, next state DCMP.
  - Divide with operand_b=0: quotient=16'hFFFF, remainder=operand_a, next state DONE. The ALU is not used.
- **MUL** (16 cycles)
  - alu_ctrl=0010, alu_src1=acc.
  - alu_src2 = b[i] ? (a<<i)[15:0] : 0.
  - acc<=alu_result. Overflow bits are discarded (mod 2^16).
  - i=15 → DONE; otherwise i+1.
- **DCMP**
  - rem_s={rem[14:0], a[i]}; top<=rem[15].
  - alu_ctrl=0111, alu_src1=rem_s, alu_src2=b.
  - Register rem_s and lt<=alu_result[0].
- **DSUB**
  - alu_ctrl=0110, alu_src1=rem_s, alu_src2=b.
  - If top=1 or lt=0: rem<=alu_result and q[i]<=1. The 16-bit wrap gives the correct remainder when top=1.
  - Otherwise: rem<=rem_s and q[i]<=0.
  - i=0 → DONE; otherwise i-1 and → DCMP.
- **DONE**
  - done=1, busy=0.
  - result_lo/result_hi load from acc/0 (multiply) or q/rem (divide).
  - Next state IDLE unconditionally. start is ignored in this cycle.
- result_lo/result_hi hold their value until the next DONE or rst.
- start outside IDLE is ignored. Operand changes after acceptance have no effect.

## Timing
- Cycle 0: start accepted in IDLE.
- Multiply: busy=1 in cycles 1–16; done=1 in cycle 17.
- Divide: busy=1 in cycles 1–32 (DCMP/DSUB alternate, bit 15 first); done=1 in cycle 33.
- Divide by zero: done=1 in cycle 1; busy never asserts.
- The earliest next start is accepted in cycle done+1, back-to-back.
- ALU outputs are driven combinationally from state. The ALU result is consumed in the same cycle, with no pipeline register.
- rst mid-operation: in the next cycle, state=IDLE and all outputs are at reset values. No done pulse is issued, and the partial result is discarded.
- rst and start in the same cycle: rst wins and start is dropped.

## Test plan
- Multiply 7×5, start at cycle 0 → busy cycles 1–16, done at cycle 17, result_lo=35, result_hi=0.
- Multiply 16'h1234×16'h0100 → result_lo=16'h3400 (truncated). Multiply 16'hFFFF×16'hFFFF → result_lo=16'h0001.
- Divide 100/7 → done at cycle 33, result_lo=14, result_hi=2. Check alu_ctrl alternates 0111/0110 during cycles 1–32.
- Divide 16'hFFFF/16'h8001 → result_lo=1, result_hi=16'h7FFE. This exercises the top-bit path. Also divide 16'h0003/16'h0010 → result_lo=0, result_hi=3.
- Divide 16'h1234/0 → done at cycle 1, result_lo=16'hFFFF, result_hi=16'h1234, busy stays 0.
- Start a multiply, then:
  - pulse start with different operands at cycle 5 → ignored, result unchanged.
  - assert rst at cycle 8 → cycle 9 IDLE, busy=0, results 0, no done. A new start at cycle 10 gives done at cycle 27.
